gate_sequencer: RTL and testbench

Controller that applies a programmed sequence of gate matrices to a quantum state vector through the gate-state multiply datapath. It holds the working state vector and a small gate program store, drives the current gate and state into the combinational/pipelined matrix-vector multiplier, captures its result, and steps through the program under a start/done handshake. It sits between the host/config interface and the multiply datapath.

---
 rtl/qc_pkg.sv | 22 ++
 rtl/gate_store.sv | 41 ++++
 rtl/gate_sequencer.sv | 129 ++++++++++++
 tb/tb_gate_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/qc_pkg.sv
// Shared types for the gate sequencer: packed Q2.6 complex amplitude, common
// constants and the sequencer FSM encoding.
package qc_pkg;

    typedef struct packed {
        logic signed [7:0] re;
        logic signed [7:0] im;
    } cplx_t;

    localparam logic [7:0] ONE     = 8'h40;
    localparam logic [7:0] NEG_ONE = 8'hC0;
    localparam logic [7:0] ZERO    = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_APPLY,
        ST_CAPTURE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/gate_store.sv
// Gate program register file: one element write port, one full-matrix read
// port, cleared on reset.
module gate_store
    import qc_pkg::*;
#(
    parameter int N         = 1,
    parameter int MAX_GATES = 8,
    parameter int GW        = 3,
    localparam int D        = 1 << N
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [GW-1:0]         wr_idx,
    input  logic [N-1:0]          wr_row,
    input  logic [N-1:0]          wr_col,
    input  logic [15:0]           wr_data,
    input  logic [GW-1:0]         rd_idx,
    output logic [16*D*D-1:0]     rd_matrix
);

    cplx_t mem_reg [MAX_GATES][D*D];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < MAX_GATES; g++) begin
                for (int e = 0; e < D*D; e++) begin
                    mem_reg[g][e] <= '0;
                end
            end
        end else if (wr_en && (int'(wr_idx) < MAX_GATES)) begin
            // Row-major element index r*D+c is just the concatenation {r, c}.
            mem_reg[wr_idx][{wr_row, wr_col}] <= cplx_t'(wr_data);
        end
    end

    for (genvar gi = 0; gi < D*D; gi++) begin : g_rd
        assign rd_matrix[16*gi +: 16] = mem_reg[rd_idx][gi];
    end

endmodule

// File: rtl/gate_sequencer.sv
// Steps a programmed list of gate matrices through an external matrix-vector
// datapath, holding the working state vector between gates.
module gate_sequencer
    import qc_pkg::*;
#(
    parameter int N         = 1,
    parameter int MAX_GATES = 8,
    parameter int MULT_LAT  = 1,
    localparam int D        = 1 << N,
    localparam int GW       = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gate_wr_en,
    input  logic [GW-1:0]         gate_wr_idx,
    input  logic [N-1:0]          gate_wr_row,
    input  logic [N-1:0]          gate_wr_col,
    input  logic [15:0]           gate_wr_data,
    input  logic [16*D-1:0]       init_state,
    input  logic [GW:0]           num_gates,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [GW-1:0]         gate_idx,
    output logic [16*D-1:0]       state_out,
    output logic [16*D*D-1:0]     mult_gate,
    output logic [16*D-1:0]       mult_state,
    input  logic [16*D-1:0]       mult_result
);

    localparam logic [GW:0] K_MAX    = (GW+1)'(MAX_GATES);
    localparam logic [3:0]  LAT_LAST = 4'(MULT_LAT - 1);

    seq_state_t       state_reg;
    logic [GW:0]      k_reg;
    logic [GW-1:0]    gate_idx_reg;
    logic [3:0]       wait_reg;
    logic [16*D-1:0]  state_vec_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             store_wr_en;

    // The program may only be edited while no run is using it.
    assign store_wr_en = gate_wr_en && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    gate_store #(
        .N         (N),
        .MAX_GATES (MAX_GATES),
        .GW        (GW)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (store_wr_en),
        .wr_idx    (gate_wr_idx),
        .wr_row    (gate_wr_row),
        .wr_col    (gate_wr_col),
        .wr_data   (gate_wr_data),
        .rd_idx    (gate_idx_reg),
        .rd_matrix (mult_gate)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            gate_idx_reg  <= '0;
            wait_reg      <= '0;
            state_vec_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        k_reg     <= (num_gates > K_MAX) ? K_MAX : num_gates;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_vec_reg <= init_state;
                    gate_idx_reg  <= '0;
                    wait_reg      <= '0;
                    if (k_reg == '0) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        state_reg <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    // Inputs held stable for MULT_LAT cycles so the result is valid in CAPTURE.
                    if (wait_reg == LAT_LAST) begin
                        state_reg <= ST_CAPTURE;
                    end else begin
                        wait_reg <= wait_reg + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    state_vec_reg <= mult_result;
                    wait_reg      <= '0;
                    if ({1'b0, gate_idx_reg} == (k_reg - 1'b1)) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        gate_idx_reg <= gate_idx_reg + 1'b1;
                        state_reg    <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign gate_idx   = gate_idx_reg;
    assign state_out  = state_vec_reg;
    assign mult_state = state_vec_reg;

endmodule

// File: tb/tb_gate_sequencer.sv
// Runs two sequencers (datapath latency 1 and 3) in lockstep against a
// behavioural model of gate application and run timing.
module tb_gate_sequencer;

    localparam int N  = 1;
    localparam int D  = 2;
    localparam int MG = 8;
    localparam int GW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              gate_wr_en;
    logic [GW-1:0]     gate_wr_idx;
    logic [N-1:0]      gate_wr_row;
    logic [N-1:0]      gate_wr_col;
    logic [15:0]       gate_wr_data;
    logic [16*D-1:0]   init_state;
    logic [GW:0]       num_gates;
    logic              start;

    logic              busy1, done1, busy3, done3;
    logic [GW-1:0]     gidx1, gidx3;
    logic [16*D-1:0]   sout1, sout3, mst1, mst3, mres1, mres3;
    logic [16*D*D-1:0] mg1, mg3;

    logic [15:0]       store_m [MG][D*D];
    int                cur_idx;
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    gate_sequencer #(.N(N), .MAX_GATES(MG), .MULT_LAT(1)) u1 (
        .clk(clk), .reset(reset), .gate_wr_en(gate_wr_en), .gate_wr_idx(gate_wr_idx),
        .gate_wr_row(gate_wr_row), .gate_wr_col(gate_wr_col), .gate_wr_data(gate_wr_data),
        .init_state(init_state), .num_gates(num_gates), .start(start),
        .busy(busy1), .done(done1), .gate_idx(gidx1), .state_out(sout1),
        .mult_gate(mg1), .mult_state(mst1), .mult_result(mres1)
    );

    gate_sequencer #(.N(N), .MAX_GATES(MG), .MULT_LAT(3)) u3 (
        .clk(clk), .reset(reset), .gate_wr_en(gate_wr_en), .gate_wr_idx(gate_wr_idx),
        .gate_wr_row(gate_wr_row), .gate_wr_col(gate_wr_col), .gate_wr_data(gate_wr_data),
        .init_state(init_state), .num_gates(num_gates), .start(start),
        .busy(busy3), .done(done3), .gate_idx(gidx3), .state_out(sout3),
        .mult_gate(mg3), .mult_state(mst3), .mult_result(mres3)
    );

    // Complex Q2.6 matrix-vector product, products rescaled then summed, wrapping to 8 bits.
    function automatic logic [31:0] dp(input logic [63:0] g, input logic [31:0] s);
        logic [31:0] r;
        r = '0;
        for (int row = 0; row < D; row++) begin
            int acc_re;
            int acc_im;
            acc_re = 0;
            acc_im = 0;
            for (int c = 0; c < D; c++) begin
                int g_re, g_im, s_re, s_im;
                g_re = int'($signed(g[16*(row*D+c)+8 +: 8]));
                g_im = int'($signed(g[16*(row*D+c) +: 8]));
                s_re = int'($signed(s[16*c+8 +: 8]));
                s_im = int'($signed(s[16*c +: 8]));
                acc_re += (g_re*s_re - g_im*s_im) >>> 6;
                acc_im += (g_re*s_im + g_im*s_re) >>> 6;
            end
            r[16*row+8 +: 8] = acc_re[7:0];
            r[16*row +: 8]   = acc_im[7:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] mat(input int g);
        logic [63:0] m;
        for (int i = 0; i < D*D; i++) m[16*i +: 16] = store_m[g][i];
        return m;
    endfunction

    // Environment datapath models with latency 1 and 3.
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= dp(mg1, mst1);
        pipe3[0] <= dp(mg3, mst3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mres1 = pipe1;
    assign mres3 = pipe3[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int g = 0; g < MG; g++)
            for (int e = 0; e < D*D; e++) store_m[g][e] = '0;
        cur_idx = 0;
    endtask

    task automatic check_reset();
        check("rst_busy1", busy1, 0);  check("rst_busy3", busy3, 0);
        check("rst_done1", done1, 0);  check("rst_done3", done3, 0);
        check("rst_gidx1", gidx1, 0);  check("rst_gidx3", gidx3, 0);
        check("rst_state1", sout1, 0); check("rst_state3", sout3, 0);
        check("rst_mgate1", mg1, 0);   check("rst_mgate3", mg3, 0);
        check("rst_mstate1", mst1, 0);
    endtask

    task automatic wr(input int g, input int r, input int c, input logic [15:0] d);
        @(negedge clk);
        gate_wr_en = 1'b1; gate_wr_idx = GW'(g);
        gate_wr_row = N'(r); gate_wr_col = N'(c); gate_wr_data = d;
        store_m[g][r*D+c] = d;
        @(negedge clk);
        gate_wr_en = 1'b0;
        check("wr_mgate1", mg1, mat(cur_idx));
        check("wr_mgate3", mg3, mat(cur_idx));
    endtask

    task automatic load_gate(input int g, input logic [63:0] m);
        for (int i = 0; i < D*D; i++) wr(g, i / D, i % D, m[16*i +: 16]);
    endtask

    task automatic chk_dut(input string nm, input int t, input int lat, input int k,
                           input logic b, input logic d, input logic [GW-1:0] gi,
                           input logic [31:0] so, input logic [31:0] ms, input logic [31:0] exp_so);
        int td;
        int exp_gi;
        td = 1 + k*(lat+1);
        check({nm, "_busy"}, b, t < td);
        check({nm, "_done"}, d, t == td);
        if (t >= 1) begin
            exp_gi = (t < td) ? (t-1)/(lat+1) : ((k > 0) ? k-1 : 0);
            check({nm, "_state"}, so, exp_so);
            check({nm, "_mstate"}, ms, exp_so);
            check({nm, "_gidx"}, gi, exp_gi);
        end
    endtask

    task automatic run(input int num, input logic [31:0] init, input bit inject,
                       input int rst_at, input bit wr_start);
        int k;
        int tmax;
        int j1, j3;
        logic [31:0] exp_st [MG+1];
        @(negedge clk);
        init_state = init;
        num_gates  = (GW+1)'(num);
        start      = 1'b1;
        if (wr_start) begin
            gate_wr_en   = 1'b1;
            gate_wr_idx  = GW'($urandom_range(0, MG-1));
            gate_wr_row  = N'($urandom_range(0, D-1));
            gate_wr_col  = N'($urandom_range(0, D-1));
            gate_wr_data = 16'($urandom);
            store_m[gate_wr_idx][int'(gate_wr_row)*D + int'(gate_wr_col)] = gate_wr_data;
        end
        k = (num > MG) ? MG : num;
        exp_st[0] = init;
        for (int j = 1; j <= k; j++) exp_st[j] = dp(mat(j-1), exp_st[j-1]);
        tmax = 1 + k*4 + 2;
        for (int t = 0; t <= tmax; t++) begin
            @(negedge clk);
            start = 1'b0;
            gate_wr_en = 1'b0;
            if (rst_at >= 0 && t == rst_at + 1) begin
                check_reset();
                reset = 1'b0;
                clear_model();
                $display("run num=%0d k=%0d interrupted by reset at t=%0d", num, k, rst_at);
                return;
            end
            j1 = (t >= 1) ? (((t-1)/2 > k) ? k : (t-1)/2) : 0;
            j3 = (t >= 1) ? (((t-1)/4 > k) ? k : (t-1)/4) : 0;
            chk_dut("lat1", t, 1, k, busy1, done1, gidx1, sout1, mst1, exp_st[j1]);
            chk_dut("lat3", t, 3, k, busy3, done3, gidx3, sout3, mst3, exp_st[j3]);
            if (inject && k >= 1 && t == 2) begin
                start        = 1'b1;
                gate_wr_en   = 1'b1;
                gate_wr_idx  = GW'($urandom_range(0, MG-1));
                gate_wr_row  = N'($urandom_range(0, D-1));
                gate_wr_col  = N'($urandom_range(0, D-1));
                gate_wr_data = 16'($urandom);
            end
            if (t == rst_at) reset = 1'b1;
        end
        cur_idx = (k > 0) ? k-1 : 0;
        $display("run num=%0d k=%0d init=%h inject=%0d final=%h", num, k, init, inject, exp_st[k]);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; gate_wr_en = 1'b0; gate_wr_idx = '0;
        gate_wr_row = '0; gate_wr_col = '0; gate_wr_data = '0;
        init_state = '0; num_gates = '0;
        clear_model();
        repeat (3) @(negedge clk);
        check_reset();
        reset = 1'b0;

        // Identity then X/Z from |0>.
        load_gate(0, {16'h4000, 16'h0000, 16'h0000, 16'h4000});
        run(1, 32'h0000_4000, 1'b0, -1, 1'b0);
        load_gate(0, {16'h0000, 16'h4000, 16'h4000, 16'h0000});
        load_gate(1, {16'hC000, 16'h0000, 16'h0000, 16'h4000});
        run(2, 32'h0000_4000, 1'b0, -1, 1'b0);
        check("xz_elem1", sout1[31:16], 16'hC000);
        check("xz_elem0", sout1[15:0], 16'h0000);
        run(0, 32'h1234_5678, 1'b0, -1, 1'b0);

        for (int it = 0; it < 6; it++) begin
            for (int g = 0; g < MG; g++) load_gate(g, {$urandom, $urandom});
            run($urandom_range(0, 15), $urandom, 1'($urandom), -1, 1'($urandom));
        end
        run(15, $urandom, 1'b1, -1, 1'b0);

        // Reset during APPLY of gate 1, then a fresh program.
        run(3, $urandom, 1'b0, 3, 1'b0);
        load_gate(0, {16'h0000, 16'h4000, 16'h4000, 16'h0000});
        load_gate(1, {$urandom, $urandom});
        run(2, $urandom, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
